// File: rtl/warmboot_pkg.sv
// Shared definitions for the warm-boot sequencer: FSM state encoding and
// default parameter values used by the sequencer, its synchroniser and the
// configuration handshake interface.
package warmboot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUAL    = 2'd1,
    ST_REQ     = 2'd2,
    ST_RELEASE = 2'd3
  } wb_state_e;

  localparam int unsigned DEF_SLOT_W      = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_HOLD_CYC    = 8;
  localparam int unsigned DEF_TIMEOUT_CYC = 1024;
  localparam int unsigned DEF_CNT_W       = 10;

endpackage

// File: rtl/warmboot_seq_ctrl_if.sv
// Request/acknowledge link between the warm-boot sequencer (master) and the
// configuration engine (slave). cfg_slot_o is stable whenever cfg_req_o is 1.
interface warmboot_seq_ctrl_if #(
  parameter int unsigned SLOT_W = warmboot_pkg::DEF_SLOT_W
);

  logic              cfg_req_o;
  logic [SLOT_W-1:0] cfg_slot_o;
  logic              cfg_ack_i;

  modport master (
    output cfg_req_o,
    output cfg_slot_o,
    input  cfg_ack_i
  );

  modport slave (
    input  cfg_req_o,
    input  cfg_slot_o,
    output cfg_ack_i
  );

endinterface

// File: rtl/warmboot_sync.sv
// Multi-bit flop-chain synchroniser. Each bit is synchronised independently;
// the sequencer tolerates bus skew because it requalifies whenever the
// synchronised slot value changes.
module warmboot_sync
  import warmboot_pkg::*;
#(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  // Shift the asynchronous inputs through the synchroniser chain.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge (synchronous), and every stage
    // is cleared so no stale boot request survives a reset.
    if (!resetn) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, giving a true STAGES-deep shift chain.
      sync_q[0] <= d_i;
      for (int i = 1; i < int'(STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/warmboot_seq_ctrl.sv
// Warm-boot sequencer: qualifies a synchronised fabric boot request, latches
// the requested slot and runs one req/ack reload transaction with timeout.
module warmboot_seq_ctrl
  import warmboot_pkg::*;
#(
  parameter int unsigned SLOT_W      = DEF_SLOT_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned HOLD_CYC    = DEF_HOLD_CYC,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic                UserCLK,
  input  logic                resetn,
  input  logic                boot_i,
  input  logic [SLOT_W-1:0]   slot_i,
  input  logic                enable_i,
  warmboot_seq_ctrl_if.master cfg_if,
  output logic                busy_o,
  output logic                err_o
);

  // QUAL counts 1..HOLD_CYC. REQ counts from 0, so the value seen during the
  // TIMEOUT_CYC-th request cycle is TIMEOUT_CYC-1 and fits in CNT_W bits.
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [SLOT_W:0]   sync_out;
  logic              bs;
  logic [SLOT_W-1:0] ss;

  wb_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] cfg_slot_q;
  logic              req_q;
  logic              busy_q;
  logic              err_q;

  warmboot_sync #(
    .WIDTH  (SLOT_W + 1),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (UserCLK),
    .resetn (resetn),
    .d_i    ({boot_i, slot_i}),
    .q_o    (sync_out)
  );

  assign bs = sync_out[SLOT_W];
  assign ss = sync_out[SLOT_W-1:0];

  // Sequencer FSM with counter and registered outputs.
  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      slot_q     <= '0;
      cfg_slot_q <= '0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bs && enable_i) begin
            state_q <= ST_QUAL;
            cnt_q   <= CNT_W'(1);
            slot_q  <= ss;
            busy_q  <= 1'b1;
          end
        end

        ST_QUAL: begin
          if (!bs || (ss != slot_q) || !enable_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == HOLD_LAST) begin
            state_q    <= ST_REQ;
            cnt_q      <= '0;
            cfg_slot_q <= slot_q;
            req_q      <= 1'b1;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_REQ: begin
          // Ack is tested first so an ack in the final cycle beats the timeout.
          if (cfg_if.cfg_ack_i) begin
            state_q <= ST_RELEASE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_q <= ST_RELEASE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            err_q   <= 1'b1;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_RELEASE: begin
          // One request per rising level: BOOT must fall before re-arming.
          if (!bs) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_if.cfg_req_o  = req_q;
  assign cfg_if.cfg_slot_o = cfg_slot_q;
  assign busy_o            = busy_q;
  assign err_o             = err_q;

endmodule

// File: tb/tb_warmboot_seq_ctrl.sv
// Self-checking bench for warmboot_seq_ctrl: directed scenarios followed by
// randomized pulse/ack-delay trials checked against timing rules.
module tb_warmboot_seq_ctrl;

  localparam int SLOT_W      = 4;
  localparam int SYNC_STAGES = 2;
  localparam int HOLD_CYC    = 8;
  localparam int TIMEOUT_CYC = 1024;
  localparam int CNT_W       = 10;

  // Cycles from driving a stable boot_i to cfg_req_o high.
  localparam int LAT = SYNC_STAGES + HOLD_CYC + 1;
  // Minimum boot_i pulse (in cycles) that still produces a request: the FSM
  // must see BOOT on the entry edge plus HOLD_CYC qualifying edges.
  localparam int MIN_PULSE = HOLD_CYC + 1;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              boot = 1'b0;
  logic              en = 1'b0;
  logic [SLOT_W-1:0] slot = '0;
  logic              busy;
  logic              err;

  int n_tests = 0;
  int n_fail  = 0;

  warmboot_seq_ctrl_if #(.SLOT_W(SLOT_W)) cfg_if ();

  warmboot_seq_ctrl #(
    .SLOT_W      (SLOT_W),
    .SYNC_STAGES (SYNC_STAGES),
    .HOLD_CYC    (HOLD_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) dut (
    .UserCLK  (clk),
    .resetn   (resetn),
    .boot_i   (boot),
    .slot_i   (slot),
    .enable_i (en),
    .cfg_if   (cfg_if),
    .busy_o   (busy),
    .err_o    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; inputs change and outputs are sampled 1 ns later.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait (bounded) for cfg_req_o to rise; returns cycles elapsed or -1.
  task automatic wait_req(input int limit, output int cycles);
    cycles = 0;
    while (cfg_if.cfg_req_o !== 1'b1 && cycles < limit) begin
      cyc(1);
      cycles++;
    end
    if (cfg_if.cfg_req_o !== 1'b1) cycles = -1;
  endtask

  // Run n cycles and count how many sample points show cfg_req_o high.
  task automatic count_req(input int n, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1);
      if (cfg_if.cfg_req_o === 1'b1) highs++;
    end
  endtask

  task automatic pulse_ack();
    cfg_if.cfg_ack_i = 1'b1;
    cyc(1);
    cfg_if.cfg_ack_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int highs;
    int p, d, s;
    int rise, width;
    bit accepted;
    logic [SLOT_W-1:0] exp_slot;

    cfg_if.cfg_ack_i = 1'b0;

    // 1) Reset, then a clean request for slot 5.
    resetn = 1'b0;
    cyc(3);
    check("rst_req",  cfg_if.cfg_req_o,  0);
    check("rst_slot", cfg_if.cfg_slot_o, 0);
    check("rst_busy", busy, 0);
    check("rst_err",  err, 0);

    resetn = 1'b1;
    en     = 1'b1;
    slot   = 4'h5;
    boot   = 1'b1;
    wait_req(40, lat);
    check("t1_latency", lat, LAT);
    check("t1_slot", cfg_if.cfg_slot_o, 5);
    check("t1_busy", busy, 1);
    pulse_ack();
    check("t1_req_drop", cfg_if.cfg_req_o, 0);
    check("t1_err", err, 0);

    // 5) BOOT held high after ack: no second request; drop and re-raise.
    count_req(30, highs);
    check("t5_no_retrigger", highs, 0);
    check("t5_busy_release", busy, 1);
    boot = 1'b0;
    cyc(SYNC_STAGES + 1);
    check("t5_back_idle", busy, 0);
    slot = 4'h7;
    boot = 1'b1;
    wait_req(40, lat);
    check("t5_second_latency", lat, LAT);
    check("t5_second_slot", cfg_if.cfg_slot_o, 7);
    pulse_ack();
    boot = 1'b0;
    cyc(6);

    // 2) Short BOOT pulse is filtered out.
    slot = 4'h2;
    boot = 1'b1;
    cyc(4);
    check("t2_busy_during", busy, 1);
    cyc(1);
    boot = 1'b0;
    count_req(20, highs);
    check("t2_no_req", highs, 0);
    check("t2_idle", busy, 0);
    check("t2_slot_kept", cfg_if.cfg_slot_o, 7);

    // 3) Slot change during qualification restarts it (one extra IDLE cycle).
    slot = 4'h3;
    boot = 1'b1;
    cyc(5);
    slot = 4'h9;
    wait_req(40, lat);
    check("t3_restart_latency", lat, LAT + 1);
    check("t3_slot", cfg_if.cfg_slot_o, 9);
    pulse_ack();
    boot = 1'b0;
    cyc(6);

    // Enable blocks acceptance; changes during REQ are ignored.
    en   = 1'b0;
    slot = 4'h1;
    boot = 1'b1;
    count_req(20, highs);
    check("en_block_req", highs, 0);
    check("en_block_busy", busy, 0);
    en = 1'b1;
    wait_req(40, lat);
    check("en_release_latency", lat, HOLD_CYC + 1);
    en   = 1'b0;
    slot = 4'h4;
    cyc(5);
    check("req_ignores_en", cfg_if.cfg_req_o, 1);
    check("req_slot_frozen", cfg_if.cfg_slot_o, 1);
    en = 1'b1;
    pulse_ack();
    boot = 1'b0;
    cyc(6);

    // 4a) Ack in the very last request cycle wins over the timeout.
    slot = 4'h6;
    boot = 1'b1;
    wait_req(40, lat);
    check("t4a_latency", lat, LAT);
    cyc(TIMEOUT_CYC - 1);
    check("t4a_req_held", cfg_if.cfg_req_o, 1);
    pulse_ack();
    check("t4a_req", cfg_if.cfg_req_o, 0);
    check("t4a_err", err, 0);
    boot = 1'b0;
    cyc(6);

    // 4b) No ack: timeout after TIMEOUT_CYC request cycles, err is sticky.
    slot = 4'hA;
    boot = 1'b1;
    wait_req(40, lat);
    check("t4b_latency", lat, LAT);
    cyc(TIMEOUT_CYC - 1);
    check("t4b_req_before", cfg_if.cfg_req_o, 1);
    check("t4b_err_before", err, 0);
    cyc(1);
    check("t4b_req_after", cfg_if.cfg_req_o, 0);
    check("t4b_err_after", err, 1);
    boot = 1'b0;
    cyc(6);
    check("t4b_err_sticky", err, 1);
    check("t4b_idle", busy, 0);

    // 6) Reset during a request aborts it; a later ack does nothing.
    slot = 4'hC;
    boot = 1'b1;
    wait_req(40, lat);
    check("t6_latency", lat, LAT);
    resetn = 1'b0;
    cyc(1);
    check("t6_req", cfg_if.cfg_req_o, 0);
    check("t6_busy", busy, 0);
    check("t6_err_cleared", err, 0);
    check("t6_slot", cfg_if.cfg_slot_o, 0);
    resetn = 1'b1;
    boot   = 1'b0;
    cfg_if.cfg_ack_i = 1'b1;
    cyc(4);
    cfg_if.cfg_ack_i = 1'b0;
    check("t6_ack_req", cfg_if.cfg_req_o, 0);
    check("t6_ack_busy", busy, 0);
    check("t6_ack_err", err, 0);

    // Randomized trials: pulse length p, ack delay d, slot s.
    // Model: a request appears iff p >= MIN_PULSE; it rises LAT cycles after
    // BOOT goes high and stays high for exactly d cycles (ack on its d-th
    // cycle). Acks arriving while no request is pending are ignored.
    exp_slot = '0;
    for (int it = 0; it < 12; it++) begin
      p = int'($urandom_range(1, 30));
      d = int'($urandom_range(1, 30));
      s = int'($urandom_range(0, 15));
      accepted = (p >= MIN_PULSE);
      rise  = -1;
      width = 0;
      slot  = SLOT_W'(s);
      boot  = 1'b1;
      for (int t = 1; t <= 70; t++) begin
        cyc(1);
        if (cfg_if.cfg_req_o === 1'b1) begin
          if (rise < 0) rise = t;
          width++;
        end
        if (t == p) boot = 1'b0;
        cfg_if.cfg_ack_i = (t == LAT + d - 1);
      end
      cfg_if.cfg_ack_i = 1'b0;
      if (accepted) exp_slot = SLOT_W'(s);
      check($sformatf("rnd%0d_rise p=%0d", it, p), rise, accepted ? LAT : -1);
      check($sformatf("rnd%0d_width d=%0d", it, d), width, accepted ? d : 0);
      check($sformatf("rnd%0d_slot", it), cfg_if.cfg_slot_o, exp_slot);
      check($sformatf("rnd%0d_err", it), err, 0);
      check($sformatf("rnd%0d_idle", it), busy, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
